// File: rtl/ex_div_ctrl.sv
// Radix-2 restoring divide sequencer for EX (DIV / DIVU), one quotient bit per cycle.
// Latency: ready_o rises DATA_W+1 edges after accept (2 edges for a zero divisor).
// Backpressure: stall_o holds IF..EX while start_i is up; result held in END until start_i drops.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-low reset
//   start_i, annul_i       divide request (held by EX) / flush that cancels the divide
//   signed_i               1 = DIV, 0 = DIVU; sampled with the accept
//   opdata1_i, opdata2_i   dividend / divisor; sampled only on the accept cycle
//   result_o, ready_o      {remainder, quotient} and its valid flag
//   stall_o                combinational stall request to the stall unit
module ex_div_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stall_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
    localparam logic [DATA_W-1:0] ZERO     = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DATA_W);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // quo_q starts as |dividend| and shifts left; quotient bits enter at the lsb.
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                neg_a, neg_b;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic [DATA_W:0]     r_ext, diff;
    logic [DATA_W-1:0]   quo_fin, rem_fin;
    logic                accept;

    // Operand magnitudes; sign flags are only ever set for signed divides, so the
    // final sign fix-up is a no-op for DIVU.
    assign neg_a = signed_i & opdata1_i[DATA_W-1];
    assign neg_b = signed_i & opdata2_i[DATA_W-1];
    assign abs_a = neg_a ? (~opdata1_i + ONE) : opdata1_i;
    assign abs_b = neg_b ? (~opdata2_i + ONE) : opdata2_i;

    // Trial subtract keeps the bit shifted out of the partial remainder, so divisors
    // with their msb set still divide correctly. diff[DATA_W] set means r < |b|.
    assign r_ext = {rem_q, quo_q[DATA_W-1]};
    assign diff  = r_ext - {1'b0, dvs_q};

    assign quo_fin = (sign_a_q ^ sign_b_q) ? (~quo_q + ONE) : quo_q;
    assign rem_fin = sign_a_q ? (~rem_q + ONE) : rem_q;

    assign accept = start_i & ~annul_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b0;
                if (accept) begin
                    sign_a_d = neg_a;
                    sign_b_d = neg_b;
                    dvs_d    = abs_b;
                    rem_d    = ZERO;
                    cnt_d    = '0;
                    if (opdata2_i == ZERO) begin
                        quo_d   = ZERO;
                        state_d = S_DIVZERO;
                    end else begin
                        quo_d   = abs_a;
                        state_d = S_ON;
                    end
                end
            end

            // Quotient and remainder are already zero. Spend one cycle here so the
            // result is registered by the same finalize step the normal path uses.
            S_DIVZERO: begin
                if (annul_i) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d = CNT_ONE;
                end else begin
                    result_d = {rem_fin, quo_fin};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end

            S_ON: begin
                if (annul_i) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q != CNT_DONE) begin
                    rem_d = diff[DATA_W] ? r_ext[DATA_W-1:0] : diff[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    result_d = {rem_fin, quo_fin};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end

            S_END: begin
                if (annul_i || !start_i) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                ready_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    // Gated by rst_i so the stall unit sees no request while reset is asserted,
    // even if EX is still holding start_i.
    assign stall_o  = rst_i & accept & (state_q != S_END);

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl: directed divides, zero divisor, overflow,
// annul and reset mid-divide, result hold in END.
module tb_ex_div_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    ex_div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          rdy_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    logic rdy_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each rising ready_o is matched against the oldest expected result.
    always @(negedge clk_i) begin
        if (ready_o === 1'b1 && rdy_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: ready_o rose at edge %0d with nothing expected", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", result_o, e.res);
                chk("ready_edge", 64'(cyc), 64'(e.rdy_cyc));
            end
        end
        rdy_prev = ready_o;
    end

    // One divide: accept, scramble operands afterwards, wait for ready, hold, release.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input bit zero, input int hold);
        int   acc;
        int   n;
        exp_t e;
        @(posedge clk_i); #1;
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        acc       = cyc + 1;
        e.res     = exp;
        e.rdy_cyc = acc + (zero ? 2 : 33);
        sb_q.push_back(e);
        @(negedge clk_i);
        chk("stall_accept", 64'(stall_o), 64'd1);
        @(posedge clk_i); #1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~sgn;
        n = 0;
        while (ready_o !== 1'b1 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        if (ready_o !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: ready_o=%b after %0d cycles, required 1", ready_o, n);
        end else begin
            chk("stall_end", 64'(stall_o), 64'd0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk_i);
                chk("ready_hold", 64'(ready_o), 64'd1);
            end
        end
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("ready_drop", 64'(ready_o), 64'd0);
    endtask

    initial begin
        int acc;
        rst_i     = 1'b0;
        start_i   = 1'b1;
        annul_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        #12;
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 0);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 0);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b0, 0);
        run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 1'b0, 0);
        run_div(1'b0, 32'd5, 32'd0, 64'd0, 1'b1, 0);
        run_div(1'b1, 32'hFFFFFFFB, 32'd0, 64'd0, 1'b1, 0);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0, 0);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 1'b0, 0);
        run_div(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, {32'd1, 32'd1}, 1'b0, 0);
        run_div(1'b0, 32'h12345678, 32'h00000100, {32'h00000078, 32'h00123456}, 1'b0, 0);

        // start and annul together in IDLE: no accept, no stall
        @(posedge clk_i); #1;
        start_i = 1'b1; annul_i = 1'b1; signed_i = 1'b0;
        opdata1_i = 32'd50; opdata2_i = 32'd5;
        @(negedge clk_i);
        chk("stall_annul_idle", 64'(stall_o), 64'd0);
        @(posedge clk_i); #1;
        start_i = 1'b0; annul_i = 1'b0;

        // annul in the middle of a DIVU
        @(posedge clk_i); #1;
        start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        acc = cyc + 1;
        while (cyc < acc + 10) begin
            @(posedge clk_i); #1;
        end
        annul_i = 1'b1;
        @(negedge clk_i);
        chk("stall_annul_on", 64'(stall_o), 64'd0);
        @(posedge clk_i); #1;
        annul_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_annul", 64'(ready_o), 64'd0);
        repeat (40) @(negedge clk_i);
        chk("ready_annul_quiet", 64'(ready_o), 64'd0);
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 0);

        // asynchronous reset in the middle of ON, start_i still held
        @(posedge clk_i); #1;
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5;
        repeat (10) @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_stall", 64'(stall_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (40) @(negedge clk_i);
        chk("ready_after_rst", 64'(ready_o), 64'd0);
        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 3);

        repeat (3) @(negedge clk_i);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
